cpu_controller: RTL and testbench
=================================

# cpu_controller

Multicycle instruction controller that drives the 16-bit datapath's ALU and register file. It latches a 16-bit instruction, decodes it, and sequences the register reads, ALU execute, status capture and writeback as one-hot control pulses. It sits between the instruction source (start/load handshake) and the datapath's control inputs: `ALUop`, operand selects, and register-file read/write.

## Interface
- `WIDTH`, 16, datapath and instruction width. Only 16 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_instr`  in  16  instruction word.
- `load`  in  1  captures `in_instr` into the IR. Honoured only in WAIT.
- `s`  in  1  start request, level-sampled in WAIT.
- `w`  out  1  1 iff the state is WAIT (ready).
- `illegal`  out  1  one-cycle pulse: undefined opcode/op.
- `readnum`, `writenum`  out  3  register-file read and write addresses.
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for the A, B, C and status registers.
- `asel`  out  1  1 forces ALU input A to 0.
- `bsel`  out  1  1 selects `sximm5` for B.
- `vsel`  out  2  writeback source select: 00 = C, 10 = `sximm8`. The controller never drives the other codes.
- `shift`  out  2  B-path shifter control.
- `ALUop`  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT.
- `sximm8`, `sximm5`  out  16  sign-extended IR[7:0] and IR[4:0], combinational from the IR.

## Operation
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Supported instructions:
  - MOV Rn,#imm8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD: opcode 101, op 00.
  - CMP: opcode 101, op 01.
  - AND: opcode 101, op 10.
  - MVN: opcode 101, op 11.
  - Every other opcode/op combination is illegal.
- Registered state: the IR (16 bits) and the FSM state. All control outputs are decoded from the state and the IR (Moore style).
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
- Transitions:
  - WAIT: to DECODE when `s`=1, otherwise stay in WAIT.
  - DECODE, by instruction:
    - MOV imm: to WR_IMM.
    - ADD, CMP, AND: to GET_A.
    - MOV reg, MVN: to GET_B.
    - Illegal: to WAIT, with `illegal`=1 for that DECODE cycle.
  - GET_A: to GET_B.
  - GET_B: to EXEC.
  - EXEC: to WAIT for CMP; to WR_REG otherwise.
  - WR_REG: to WAIT.
  - WR_IMM: to WAIT.
- Per-state outputs (all unlisted outputs are 0):
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - EXEC: `shift`=sh.
    - `ALUop`=op for ADD, CMP, AND and MVN.
    - For MOV reg: `ALUop`=00 and `asel`=1.
    - `loadc`=1 for all instructions except CMP. CMP asserts `loads`=1 and `loadc`=0.
  - WR_REG: `writenum`=Rd, `vsel`=00, `write`=1.
  - WR_IMM: `writenum`=Rn, `vsel`=10, `write`=1.
- `load` in WAIT updates the IR at the same edge at which `s` is sampled. `load` and `s` together start the newly loaded instruction.
- `load` outside WAIT is ignored; the IR is stable for the whole instruction.
- `s` held high causes back-to-back instructions. The IR is re-executed unless it is reloaded.

## Timing
- Reset: at the edge where `reset`=1, the state becomes WAIT and the IR becomes 0x0000. The next cycle shows `w`=1 with all enables, `illegal`, selects, addresses and `ALUop` at 0.
- Reset has priority over `s` and `load`.
- Reset in any state aborts the instruction. No `write`, `loadc` or `loads` is asserted after the reset edge.
- Latency is counted in cycles with `w`=0 after `s` is sampled:
  - MOV imm: 2.
  - CMP: 4.
  - MOV reg and MVN: 4.
  - ADD and AND: 5.
  - Illegal: 1.
- `write` is asserted for exactly one cycle per writing instruction, and always in the final non-WAIT cycle.

## Test plan
- Reset with `s`=1 and `load`=1 asserted -> next cycle `w`=1, IR=0, `write`=0, all loads 0.
- `in_instr`=0xD007 with `load`=`s`=1 -> DECODE, then WR_IMM with `write`=1, `writenum`=0, `vsel`=10, `sximm8`=0x0007, then `w`=1. Then 0xD1FF -> `sximm8`=0xFFFF.
- 0xA148 (ADD R2,R1,R0,LSL#1) -> the following sequence, then `w`=1 after 5 cycles:
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1.
  - EXEC: `ALUop`=00, `shift`=01, `loadc`=1.
  - WR_REG: `writenum`=2, `write`=1.
- 0xA800 (CMP R0,R0) -> EXEC has `ALUop`=01, `loads`=1, `loadc`=0. `write` is never asserted. Back in WAIT after 4 cycles.
- 0xB860 (MVN R3,R0) -> GET_A is skipped. EXEC has `ALUop`=11. WR_REG has `writenum`=3. Then 0xC060 (MOV R3,R0) -> EXEC has `asel`=1, `ALUop`=00.
- 0x0000 -> DECODE with `illegal`=1, then WAIT, with no `write` or loads. Reset asserted during EXEC of 0xA148 -> WAIT next cycle, and `write` stays 0.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle controller for the 16-bit ALU/register-file datapath.
// Latches an instruction into the IR, decodes it and emits one-hot control
// pulses for operand reads, ALU execute, status capture and writeback.
module cpu_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             load,
  input  logic             s,
  output logic             w,
  output logic             illegal,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5
);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] ir_reg;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir_reg[15:13];
  assign op     = ir_reg[12:11];
  assign rn     = ir_reg[10:8];
  assign rd     = ir_reg[7:5];
  assign sh     = ir_reg[4:3];
  assign rm     = ir_reg[2:0];

  // Instruction class decode
  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  // Immediates are pure functions of the IR
  assign sximm8 = {{(WIDTH-8){ir_reg[7]}}, ir_reg[7:0]};
  assign sximm5 = {{(WIDTH-5){ir_reg[4]}}, ir_reg[4:0]};

  // IR capture: only while idle, so the word is stable for the whole instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg <= '0;
    end else if (state_reg == ST_WAIT && load) begin
      ir_reg <= in_instr;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT:   state_next = s ? ST_DECODE : ST_WAIT;
      ST_DECODE: begin
        if (is_mov_imm)                state_next = ST_WR_IMM;
        else if (is_alu && !is_mvn)    state_next = ST_GET_A;
        else if (is_mov_reg || is_mvn) state_next = ST_GET_B;
        else                           state_next = ST_WAIT;
      end
      ST_GET_A:  state_next = ST_GET_B;
      ST_GET_B:  state_next = ST_EXEC;
      ST_EXEC:   state_next = is_cmp ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_next = ST_WAIT;
      ST_WR_IMM: state_next = ST_WAIT;
      default:   state_next = ST_WAIT;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_reg)
      ST_WAIT:   w = 1'b1;
      ST_DECODE: illegal = !(is_mov_imm || is_mov_reg || is_alu);
      ST_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      ST_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      ST_EXEC: begin
        shift = sh;
        if (is_mov_reg) begin
          // MOV reg passes B through the adder with A forced to zero
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        loads = is_cmp;
        loadc = !is_cmp;
      end
      ST_WR_REG: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
      end
      ST_WR_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: walks each instruction class
// state by state and compares the full control bundle each cycle.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_instr;
  logic        load;
  logic        s;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int errors = 0;

  cpu_controller #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .load(load), .s(s),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  logic [20:0] obs_ctrl;
  assign obs_ctrl = {w, illegal, readnum, writenum, write, loada, loadb,
                     loadc, loads, asel, bsel, vsel, shift, ALUop};

  function automatic logic [20:0] ctrl(
    input logic wv, input logic ill, input logic [2:0] rn, input logic [2:0] wn,
    input logic wr, input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic bs, input logic [1:0] vs, input logic [1:0] sh,
    input logic [1:0] op);
    return {wv, ill, rn, wn, wr, la, lb, lc, ls, as, bs, vs, sh, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then examined 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] instr);
    in_instr = instr;
    load = 1'b1;
    s = 1'b1;
    step();
    load = 1'b0;
    s = 1'b0;
    in_instr = 16'h0000;
  endtask

  logic [20:0] idle;
  logic [20:0] zero;

  initial begin
    idle = ctrl(1,0,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00);
    zero = '0;

    // Reset dominates simultaneous s and load
    reset = 1'b1; s = 1'b1; load = 1'b1; in_instr = 16'hD007;
    step();
    reset = 1'b0; s = 1'b0; load = 1'b0; in_instr = 16'h0000;
    chk("rst_ctrl", 32'(obs_ctrl), 32'(idle));
    chk("rst_ir", 32'(sximm8), 32'h0);

    // MOV R0,#7
    start(16'hD007);
    chk("movi_dec", 32'(obs_ctrl), 32'(zero));
    chk("movi_imm8", 32'(sximm8), 32'h0007);
    step();
    chk("movi_wr", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,1,0,0,0,0,0,0,2'b10,2'b00,2'b00)));
    step();
    chk("movi_done", 32'(obs_ctrl), 32'(idle));

    // MOV R1,#-1
    start(16'hD1FF);
    chk("movi2_imm8", 32'(sximm8), 32'hFFFF);
    chk("movi2_imm5", 32'(sximm5), 32'hFFFF);
    step();
    chk("movi2_wr", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd1,1,0,0,0,0,0,0,2'b10,2'b00,2'b00)));
    step();
    chk("movi2_done", 32'(obs_ctrl), 32'(idle));

    // ADD R2,R1,R0,LSL#1 with a stray load that must be ignored
    start(16'hA148);
    chk("add_dec", 32'(obs_ctrl), 32'(zero));
    load = 1'b1; in_instr = 16'hFFFF;
    step();
    load = 1'b0; in_instr = 16'h0000;
    chk("add_geta", 32'(obs_ctrl), 32'(ctrl(0,0,3'd1,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00)));
    chk("add_ir_hold", 32'(sximm8), 32'h0048);
    chk("add_imm5", 32'(sximm5), 32'h0008);
    step();
    chk("add_getb", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("add_exec", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,0,1,0,0,0,2'b00,2'b01,2'b00)));
    step();
    chk("add_wr", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd2,1,0,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("add_done", 32'(obs_ctrl), 32'(idle));

    // CMP R0,R0
    start(16'hA800);
    chk("cmp_dec", 32'(obs_ctrl), 32'(zero));
    step();
    chk("cmp_geta", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("cmp_getb", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("cmp_exec", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,0,0,1,0,0,2'b00,2'b00,2'b01)));
    step();
    chk("cmp_done", 32'(obs_ctrl), 32'(idle));

    // MVN R3,R0
    start(16'hB860);
    chk("mvn_dec", 32'(obs_ctrl), 32'(zero));
    step();
    chk("mvn_getb", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("mvn_exec", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,0,1,0,0,0,2'b00,2'b00,2'b11)));
    step();
    chk("mvn_wr", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd3,1,0,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("mvn_done", 32'(obs_ctrl), 32'(idle));

    // MOV R3,R0
    start(16'hC060);
    chk("movr_dec", 32'(obs_ctrl), 32'(zero));
    step();
    chk("movr_getb", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("movr_exec", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00)));
    step();
    chk("movr_wr", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd3,1,0,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("movr_done", 32'(obs_ctrl), 32'(idle));

    // Illegal: opcode 000, and opcode 110 with op 11
    start(16'h0000);
    chk("ill0_dec", 32'(obs_ctrl), 32'(ctrl(0,1,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("ill0_done", 32'(obs_ctrl), 32'(idle));
    start(16'hD800);
    chk("ill1_dec", 32'(obs_ctrl), 32'(ctrl(0,1,3'd0,3'd0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00)));
    step();
    chk("ill1_done", 32'(obs_ctrl), 32'(idle));

    // Reset during EXEC of ADD aborts before writeback
    start(16'hA148);
    step();
    step();
    step();
    chk("abort_exec", 32'(obs_ctrl), 32'(ctrl(0,0,3'd0,3'd0,0,0,0,1,0,0,0,2'b00,2'b01,2'b00)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_wait", 32'(obs_ctrl), 32'(idle));
    chk("abort_ir", 32'(sximm8), 32'h0);
    step();
    chk("abort_idle", 32'(obs_ctrl), 32'(idle));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
